// File: rtl/seq_axargmax_pkg.sv
// Shared types and helpers for the streaming approximate argmax.
package axargmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [15:0] CMP_MASK_DEFAULT = 16'h1000;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_axargmax_cmp.sv
// Strict greater-than on score keys; keys are optionally masked down to the approximate bits.
module argmax_cmp
    import axargmax_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] CMP_MASK = WIDTH'(CMP_MASK_DEFAULT)
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);

    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;

    always_comb begin
        key_a  = mode ? (a & CMP_MASK) : a;
        key_b  = mode ? (b & CMP_MASK) : b;
        a_gt_b = key_a > key_b;
    end

endmodule

// File: rtl/seq_axargmax.sv
// Streaming argmax: one score per beat, one (index, value, error) result per frame.
module seq_axargmax
    import axargmax_pkg::*;
#(
    parameter int unsigned      NUM_CLASSES = 3,
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      IDX_W       = clog2(NUM_CLASSES),
    parameter logic [WIDTH-1:0] CMP_MASK    = WIDTH'(CMP_MASK_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             approx_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_val,
    output logic             out_err
);

    // One extra bit so the beat count can reach NUM_CLASSES without wrapping.
    localparam int unsigned CNT_W = IDX_W + 1;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_err_q;
    logic             mode_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [WIDTH-1:0] best_val_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             frame_end;
    logic             frame_err;
    logic             new_gt;
    logic [CNT_W-1:0] cnt_inc;

    argmax_cmp #(
        .WIDTH    (WIDTH),
        .CMP_MASK (CMP_MASK)
    ) u_cmp (
        .mode   (mode_q),
        .a      (in_data),
        .b      (best_val_q),
        .a_gt_b (new_gt)
    );

    // cnt_q is the index of the beat being presented (0 while IDLE).
    always_comb begin
        accept    = in_valid && in_ready_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        frame_end = in_last || (cnt_q == CNT_W'(NUM_CLASSES - 1));
        frame_err = !in_last || (cnt_inc < CNT_W'(NUM_CLASSES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            mode_q      <= 1'b0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            cnt_q       <= '0;
        end else begin
            in_ready_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        best_val_q <= in_data;
                        best_idx_q <= '0;
                        cnt_q      <= cnt_inc;
                        mode_q     <= approx_en;
                        if (frame_end) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_err_q   <= frame_err;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (new_gt) begin
                            best_val_q <= in_data;
                            best_idx_q <= IDX_W'(cnt_q);
                        end
                        cnt_q <= cnt_inc;
                        if (frame_end) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_err_q   <= frame_err;
                        end
                    end
                end
                HOLD: begin
                    // Ready reopens the cycle after the result handshake.
                    in_ready_q <= out_ready;
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = best_idx_q;
    assign out_val   = best_val_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_seq_axargmax.sv
// Scoreboard bench for seq_axargmax: per-scenario tasks, expected results queued at stimulus time.
`timescale 1ns/1ps
module tb_seq_axargmax;

    localparam int          NUM_CLASSES = 3;
    localparam int          WIDTH       = 16;
    localparam int          IDX_W       = 2;
    localparam logic [15:0] MASK        = 16'h1000;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] val;
        logic             err;
    } exp_t;

    typedef logic [WIDTH-1:0] scores_t [4];

    logic             clk = 1'b0;
    logic             rst;
    logic             approx_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_val;
    logic             out_err;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_axargmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .WIDTH       (WIDTH),
        .IDX_W       (IDX_W),
        .CMP_MASK    (MASK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .approx_en (approx_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_val   (out_val),
        .out_err   (out_err)
    );

    // Reference model pushes the expected result, then the frame is driven beat by beat.
    // approx_en is inverted after the first beat to show it only matters at frame start.
    task automatic send_frame(input scores_t s, input int n, input int last_pos,
                              input logic approx, output int first_wait);
        exp_t             e;
        int               fend;
        int               waits;
        logic [WIDTH-1:0] kk;
        logic [WIDTH-1:0] kb;
        fend  = (last_pos >= 0 && last_pos < NUM_CLASSES) ? last_pos : NUM_CLASSES - 1;
        e.idx = '0;
        e.val = s[0];
        for (int k = 1; k <= fend; k++) begin
            kk = approx ? (s[k] & MASK) : s[k];
            kb = approx ? (e.val & MASK) : e.val;
            if (kk > kb) begin
                e.idx = IDX_W'(k);
                e.val = s[k];
            end
        end
        e.err = (last_pos == fend) ? ((fend + 1) < NUM_CLASSES) : 1'b1;
        sb_q.push_back(e);
        first_wait = 0;
        for (int k = 0; k < n; k++) begin
            in_valid  = 1'b1;
            in_data   = s[k];
            in_last   = (k == last_pos);
            approx_en = (k == 0) ? approx : ~approx;
            waits = 0;
            while (!in_ready && waits < 20) begin
                @(posedge clk); #1;
                waits++;
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL beat_accept k=%0d: in_ready=%b, required 1 within 20 cycles", k, in_ready);
            end
            if (k == 0) first_wait = waits;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_out_idx: got %0d, required 0", out_idx); end
        checks++; if (out_val !== '0) begin errors++; $display("FAIL reset_out_val: got %0d, required 0", out_val); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_exact();
        scores_t s;
        exp_t    e;
        int      w;
        s = '{16'd100, 16'd300, 16'd200, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL exact_latency: out_valid=%b, required 1", out_valid); end
        checks++; if ({out_idx, out_val, out_err} !== e) begin errors++;
            $display("FAIL exact_result: got idx=%0d val=%0d err=%b, required idx=%0d val=%0d err=%b", out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    task automatic test_approx();
        scores_t s;
        exp_t    e;
        int      w;
        s = '{16'h1FFF, 16'h1000, 16'h0FFF, 16'h0};
        send_frame(s, 3, 2, 1'b1, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL approx_tie: got v=%b idx=%0d val=%h err=%b, required v=1 idx=%0d val=%h err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
        s = '{16'h0FFF, 16'h1000, 16'h1001, 16'h0};
        send_frame(s, 3, 2, 1'b1, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL approx_mask: got v=%b idx=%0d val=%h err=%b, required v=1 idx=%0d val=%h err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    task automatic test_ties();
        scores_t s;
        exp_t    e;
        int      w;
        s = '{16'd50, 16'd50, 16'd50, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL tie_equal: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
        s = '{16'd0, 16'd0, 16'd0, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL tie_zero: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    task automatic test_frame_length();
        scores_t s;
        exp_t    e;
        int      w;
        s = '{16'd5, 16'd9, 16'd0, 16'd0};
        send_frame(s, 2, 1, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL short_frame: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", out_err); end
        s = '{16'd4, 16'd6, 16'd2, 16'd0};
        send_frame(s, 3, -1, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL long_frame: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    task automatic test_back_to_back();
        scores_t s;
        exp_t    e;
        int      w;
        s = '{16'd11, 16'd33, 16'd22, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        e = sb_q[0];
        in_valid  = 1'b1;
        in_data   = 16'd7;
        in_last   = 1'b0;
        approx_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c=%0d: got %b, required 0", c, in_ready); end
            checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
                $display("FAIL hold_stable c=%0d: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", c, out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
            @(posedge clk); #1;
        end
        void'(sb_q.pop_front());
        release_result();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
            $display("FAIL handshake_release: got out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready); end
        s = '{16'd7, 16'd1, 16'd9, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL next_first_beat: waited %0d cycles, required 0", w); end
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL next_frame: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    task automatic test_mid_reset();
        scores_t s;
        exp_t    e;
        int      w;
        logic    seen;
        in_valid  = 1'b1;
        approx_en = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'd9;
        @(posedge clk); #1;
        in_data   = 16'd8;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        seen      = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_discard: out_valid seen=%b, required 0", seen); end
        s = '{16'd1, 16'd2, 16'd3, 16'd0};
        send_frame(s, 3, 2, 1'b0, w);
        e = sb_q.pop_front();
        checks++; if ({out_valid, out_idx, out_val, out_err} !== {1'b1, e}) begin errors++;
            $display("FAIL fresh_frame: got v=%b idx=%0d val=%0d err=%b, required v=1 idx=%0d val=%0d err=%b", out_valid, out_idx, out_val, out_err, e.idx, e.val, e.err); end
        release_result();
    endtask

    initial begin
        rst       = 1'b1;
        approx_en = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_exact();
        test_approx();
        test_ties();
        test_frame_length();
        test_back_to_back();
        test_mid_reset();
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
